// File: rtl/dp_ram_stream_rd_pkg.sv
// Shared types and helpers for the dp_ram_stream_rd burst read engine.
package dp_ram_stream_rd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ISSUE  = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_FINISH = 2'd3
   } state_t;

   // Read latency of the attached RAM as seen from the address register.
   function automatic int rd_lat(input int out_regs);
      return 1 + out_regs;
   endfunction

endpackage

// File: rtl/dp_ram_stream_rd_fifo_buf.sv
// Small registered FIFO holding {last, data} words returned by the RAM.
module fifo_buf #(
   parameter int W     = 33,
   parameter int DEPTH = 3,
   localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int OW   = $clog2(DEPTH + 1)
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          push_i,
   input  logic [W-1:0]  din_i,
   input  logic          pop_i,
   output logic [W-1:0]  dout_o,
   output logic          full_o,
   output logic          empty_o,
   output logic [OW-1:0] occ_o
);

   logic [DEPTH-1:0][W-1:0] mem_q;
   logic [PW-1:0]           wr_ptr_q, rd_ptr_q;
   logic [OW-1:0]           occ_q;

   // DEPTH is usually not a power of two, so pointers wrap explicitly.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mem_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         if (push_i) begin
            mem_q[wr_ptr_q] <= din_i;
            wr_ptr_q        <= ptr_inc(wr_ptr_q);
         end
         if (pop_i) begin
            rd_ptr_q <= ptr_inc(rd_ptr_q);
         end
         occ_q <= occ_q + OW'(push_i) - OW'(pop_i);
      end
   end

   assign dout_o  = mem_q[rd_ptr_q];
   assign full_o  = (occ_q == OW'(DEPTH));
   assign empty_o = (occ_q == '0);
   assign occ_o   = occ_q;

endmodule

// File: rtl/dp_ram_stream_rd.sv
// Burst reader for one sync_dp_ram port: issues LEN wrapped reads from BASE and
// returns them as a valid/ready stream, buffering the RAM latency with credits.
module dp_ram_stream_rd
   import dp_ram_stream_rd_pkg::*;
#(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_DEPTH = 1024,
   parameter int DATA_WIDTH = 32,
   parameter int OUT_REGS   = 0,
   parameter int LEN_WIDTH  = 16
) (
   input  logic                  Clk_CI,
   input  logic                  Rst_RBI,
   input  logic                  Start_SI,
   input  logic [ADDR_WIDTH-1:0] BaseAddr_DI,
   input  logic [LEN_WIDTH-1:0]  Len_DI,
   output logic                  Busy_SO,
   output logic                  Done_SO,
   output logic                  CSel_SO,
   output logic [ADDR_WIDTH-1:0] Addr_DO,
   input  logic [DATA_WIDTH-1:0] RdData_DI,
   output logic                  Valid_SO,
   input  logic                  Ready_SI,
   output logic [DATA_WIDTH-1:0] Data_DO,
   output logic                  Last_SO
);

   localparam int RD_LAT    = rd_lat(OUT_REGS);
   localparam int BUF_DEPTH = RD_LAT + 2;
   localparam int OW        = $clog2(BUF_DEPTH + 1);
   localparam int CW        = OW + 1;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [LEN_WIDTH-1:0]  len_q, len_d, issued_q, issued_d;
   logic [RD_LAT-1:0]     trk_q, trk_last_q;
   logic [OW-1:0]         occ;
   logic [CW-1:0]         infl;
   logic                  issue, pop, full, empty, last_out;
   logic [DATA_WIDTH:0]   buf_dout;

   assign pop = !empty && Ready_SI;

   always_comb begin
      infl = '0;
      for (int i = 0; i < RD_LAT; i++) infl = infl + CW'(trk_q[i]);
   end

   // A pop this cycle frees its slot for this cycle's issue decision.
   assign issue = (state_q == ST_ISSUE) && (issued_q < len_q) &&
                  ((CW'(occ) + infl) < (CW'(BUF_DEPTH) + CW'(pop)));

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      len_d    = len_q;
      issued_d = issued_q;
      case (state_q)
         ST_IDLE: begin
            if (Start_SI) begin
               if (Len_DI != '0) begin
                  addr_d   = BaseAddr_DI;
                  len_d    = Len_DI;
                  issued_d = '0;
                  state_d  = ST_ISSUE;
               end else begin
                  state_d  = ST_FINISH;
               end
            end
         end
         ST_ISSUE: begin
            if (issue) begin
               addr_d   = (addr_q == ADDR_WIDTH'(DATA_DEPTH - 1)) ? '0 : addr_q + 1'b1;
               issued_d = issued_q + 1'b1;
               if (issued_q + 1'b1 == len_q) state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (pop && last_out) state_d = ST_FINISH;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
      if (!Rst_RBI) begin
         state_q    <= ST_IDLE;
         addr_q     <= '0;
         len_q      <= '0;
         issued_q   <= '0;
         trk_q      <= '0;
         trk_last_q <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         len_q      <= len_d;
         issued_q   <= issued_d;
         trk_q      <= (trk_q << 1) | RD_LAT'(issue);
         trk_last_q <= (trk_last_q << 1) | RD_LAT'(issue && (issued_q == len_q - 1'b1));
      end
   end

   fifo_buf #(.W(DATA_WIDTH + 1), .DEPTH(BUF_DEPTH)) u_buf (
      .clk_i   (Clk_CI),
      .rst_ni  (Rst_RBI),
      .push_i  (trk_q[RD_LAT-1]),
      .din_i   ({trk_last_q[RD_LAT-1], RdData_DI}),
      .pop_i   (pop),
      .dout_o  (buf_dout),
      .full_o  (full),
      .empty_o (empty),
      .occ_o   (occ)
   );

   assign last_out = buf_dout[DATA_WIDTH];
   assign Busy_SO  = (state_q != ST_IDLE);
   assign Done_SO  = (state_q == ST_FINISH);
   assign CSel_SO  = issue;
   assign Addr_DO  = addr_q;
   assign Valid_SO = !empty;
   assign Data_DO  = buf_dout[DATA_WIDTH-1:0];
   assign Last_SO  = last_out && !empty;

   a_no_overflow: assert property (@(posedge Clk_CI) disable iff (!Rst_RBI)
      trk_q[RD_LAT-1] |-> !full);
   a_base_range: assert property (@(posedge Clk_CI) disable iff (!Rst_RBI)
      (state_q == ST_IDLE && Start_SI) |-> (int'(BaseAddr_DI) < DATA_DEPTH));

endmodule

// File: tb/tb_dp_ram_stream_rd.sv
// Directed bench for dp_ram_stream_rd with behavioural RAMs (mem[i] = i), OUT_REGS 0 and 1.
module tb_dp_ram_stream_rd;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        st0, st1, rdy;
   logic [9:0]  base;
   logic [15:0] len;
   logic        busy0, done0, cs0, v0, l0, busy1, done1, cs1, v1, l1;
   logic [9:0]  addr0, addr1;
   logic [31:0] d0, d1, ram0, ram1a, ram1b;
   int          n_chk = 0, n_fail = 0;

   always #5 clk = ~clk;

   dp_ram_stream_rd #(.ADDR_WIDTH(10), .DATA_DEPTH(1024), .DATA_WIDTH(32), .OUT_REGS(0), .LEN_WIDTH(16)) dut0 (
      .Clk_CI(clk), .Rst_RBI(rst_n), .Start_SI(st0), .BaseAddr_DI(base), .Len_DI(len),
      .Busy_SO(busy0), .Done_SO(done0), .CSel_SO(cs0), .Addr_DO(addr0), .RdData_DI(ram0),
      .Valid_SO(v0), .Ready_SI(rdy), .Data_DO(d0), .Last_SO(l0));

   dp_ram_stream_rd #(.ADDR_WIDTH(10), .DATA_DEPTH(1024), .DATA_WIDTH(32), .OUT_REGS(1), .LEN_WIDTH(16)) dut1 (
      .Clk_CI(clk), .Rst_RBI(rst_n), .Start_SI(st1), .BaseAddr_DI(base), .Len_DI(len),
      .Busy_SO(busy1), .Done_SO(done1), .CSel_SO(cs1), .Addr_DO(addr1), .RdData_DI(ram1b),
      .Valid_SO(v1), .Ready_SI(rdy), .Data_DO(d1), .Last_SO(l1));

   // RAM read ports: registered read, plus one output register for OUT_REGS=1.
   always_ff @(posedge clk) if (cs0) ram0 <= {22'd0, addr0};
   always_ff @(posedge clk) begin
      if (cs1) ram1a <= {22'd0, addr1};
      ram1b <= ram1a;
   end

   task automatic test_reset();
      rst_n = 1'b0; st0 = 1'b0; st1 = 1'b0; rdy = 1'b0; base = '0; len = '0;
      repeat (2) @(negedge clk);
      #1;
      n_chk++; if ({busy0, done0, cs0, v0, l0} !== 5'b0) begin n_fail++; $display("FAIL reset_ctl0 got %b exp 00000", {busy0, done0, cs0, v0, l0}); end
      n_chk++; if ({busy1, done1, cs1, v1, l1} !== 5'b0) begin n_fail++; $display("FAIL reset_ctl1 got %b exp 00000", {busy1, done1, cs1, v1, l1}); end
      n_chk++; if (addr0 !== 10'd0 || d0 !== 32'd0) begin n_fail++; $display("FAIL reset_dat0 addr %0d data %0d exp 0 0", addr0, d0); end
      n_chk++; if (addr1 !== 10'd0 || d1 !== 32'd0) begin n_fail++; $display("FAIL reset_dat1 addr %0d data %0d exp 0 0", addr1, d1); end
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      int ecs[8] = '{1, 1, 1, 1, 0, 0, 0, 0};
      int ea[8]  = '{10, 11, 12, 13, 0, 0, 0, 0};
      int ev[8]  = '{0, 0, 1, 1, 1, 1, 0, 0};
      int ed[8]  = '{0, 0, 10, 11, 12, 13, 0, 0};
      int el[8]  = '{0, 0, 0, 0, 0, 1, 0, 0};
      int edn[8] = '{0, 0, 0, 0, 0, 0, 1, 0};
      int eb[8]  = '{1, 1, 1, 1, 1, 1, 1, 0};
      logic [3:0] ectl;
      @(negedge clk); st0 = 1'b1; base = 10'd10; len = 16'd4; rdy = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk); st0 = 1'b0; #1;
         ectl = {eb[c-1] != 0, edn[c-1] != 0, ecs[c-1] != 0, ev[c-1] != 0};
         n_chk++; if ({busy0, done0, cs0, v0} !== ectl) begin n_fail++; $display("FAIL basic_ctl c=%0d got %b exp %b", c, {busy0, done0, cs0, v0}, ectl); end
         if (ecs[c-1] != 0) begin
            n_chk++; if (addr0 !== 10'(ea[c-1])) begin n_fail++; $display("FAIL basic_addr c=%0d got %0d exp %0d", c, addr0, ea[c-1]); end
         end
         if (ev[c-1] != 0) begin
            n_chk++; if (d0 !== 32'(ed[c-1]) || l0 !== (el[c-1] != 0)) begin n_fail++; $display("FAIL basic_data c=%0d got %0d/%b exp %0d/%0d", c, d0, l0, ed[c-1], el[c-1]); end
         end
      end
   endtask

   task automatic test_wrap();
      int ecs[11] = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0};
      int ea[11]  = '{1020, 1021, 1022, 1023, 0, 1, 0, 0, 0, 0, 0};
      int ev[11]  = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 0, 0};
      int ed[11]  = '{0, 0, 0, 1020, 1021, 1022, 1023, 0, 1, 0, 0};
      int el[11]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
      int edn[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
      int eb[11]  = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
      logic [3:0] ectl;
      @(negedge clk); st1 = 1'b1; base = 10'd1020; len = 16'd6; rdy = 1'b1;
      for (int c = 1; c <= 11; c++) begin
         @(negedge clk); st1 = 1'b0; #1;
         ectl = {eb[c-1] != 0, edn[c-1] != 0, ecs[c-1] != 0, ev[c-1] != 0};
         n_chk++; if ({busy1, done1, cs1, v1} !== ectl) begin n_fail++; $display("FAIL wrap_ctl c=%0d got %b exp %b", c, {busy1, done1, cs1, v1}, ectl); end
         if (ecs[c-1] != 0) begin
            n_chk++; if (addr1 !== 10'(ea[c-1])) begin n_fail++; $display("FAIL wrap_addr c=%0d got %0d exp %0d", c, addr1, ea[c-1]); end
         end
         if (ev[c-1] != 0) begin
            n_chk++; if (d1 !== 32'(ed[c-1]) || l1 !== (el[c-1] != 0)) begin n_fail++; $display("FAIL wrap_data c=%0d got %0d/%b exp %0d/%0d", c, d1, l1, ed[c-1], el[c-1]); end
         end
      end
   endtask

   task automatic test_len0();
      logic [3:0] ectl;
      @(negedge clk); st0 = 1'b1; base = 10'd10; len = 16'd0; rdy = 1'b1;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk); st0 = 1'b0; #1;
         ectl = (c == 1) ? 4'b1100 : 4'b0000;
         n_chk++; if ({busy0, done0, cs0, v0} !== ectl) begin n_fail++; $display("FAIL len0_ctl c=%0d got %b exp %b", c, {busy0, done0, cs0, v0}, ectl); end
      end
   endtask

   task automatic test_restart();
      int ecs[9] = '{1, 1, 1, 0, 0, 0, 0, 0, 0};
      int ev[9]  = '{0, 0, 1, 1, 1, 0, 0, 0, 0};
      int el[9]  = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
      int edn[9] = '{0, 0, 0, 0, 0, 1, 0, 0, 0};
      int eb[9]  = '{1, 1, 1, 1, 1, 1, 0, 0, 0};
      logic [3:0] ectl;
      @(negedge clk); st0 = 1'b1; base = 10'd20; len = 16'd3; rdy = 1'b1;
      for (int c = 1; c <= 9; c++) begin
         @(negedge clk);
         st0 = (c == 2);
         if (c == 2) begin base = 10'd500; len = 16'd7; end
         #1;
         ectl = {eb[c-1] != 0, edn[c-1] != 0, ecs[c-1] != 0, ev[c-1] != 0};
         n_chk++; if ({busy0, done0, cs0, v0} !== ectl) begin n_fail++; $display("FAIL restart_ctl c=%0d got %b exp %b", c, {busy0, done0, cs0, v0}, ectl); end
         if (ecs[c-1] != 0) begin
            n_chk++; if (addr0 !== 10'(19 + c)) begin n_fail++; $display("FAIL restart_addr c=%0d got %0d exp %0d", c, addr0, 19 + c); end
         end
         if (ev[c-1] != 0) begin
            n_chk++; if (d0 !== 32'(17 + c) || l0 !== (el[c-1] != 0)) begin n_fail++; $display("FAIL restart_data c=%0d got %0d/%b exp %0d/%0d", c, d0, l0, 17 + c, el[c-1]); end
         end
      end
   endtask

   task automatic test_stall();
      int iss = 0, acc = 0, cyc = 0;
      logic pv = 1'b0, pr = 1'b0, pl = 1'b0, lastprev = 1'b0, exp_cs;
      logic [31:0] pd = '0;
      bit fin = 1'b0, pop;
      @(negedge clk); st0 = 1'b1; base = 10'd100; len = 16'd256; rdy = 1'b1;
      while (!fin && cyc < 3000) begin
         @(negedge clk); st0 = 1'b0; rdy = ($urandom_range(0, 9) >= 3); #1; cyc++;
         pop = v0 && rdy;
         exp_cs = (iss < 256) && ((iss - acc - int'(pop)) < 3);
         n_chk++; if (cs0 !== exp_cs) begin n_fail++; $display("FAIL stall_csel cyc=%0d got %b exp %b", cyc, cs0, exp_cs); end
         if (cs0 === 1'b1) begin
            n_chk++; if (addr0 !== 10'(100 + iss)) begin n_fail++; $display("FAIL stall_addr cyc=%0d got %0d exp %0d", cyc, addr0, 100 + iss); end
            iss++;
         end
         if (pv && !pr) begin
            n_chk++; if (v0 !== 1'b1 || d0 !== pd || l0 !== pl) begin n_fail++; $display("FAIL stall_hold cyc=%0d got %b/%0d/%b exp 1/%0d/%b", cyc, v0, d0, l0, pd, pl); end
         end
         if (pop) begin
            n_chk++; if (d0 !== 32'(100 + acc) || l0 !== (acc == 255)) begin n_fail++; $display("FAIL stall_data cyc=%0d got %0d/%b exp %0d/%b", cyc, d0, l0, 100 + acc, acc == 255); end
            acc++;
         end
         if (done0 === 1'b1) begin
            fin = 1'b1;
            n_chk++; if (acc != 256 || !lastprev) begin n_fail++; $display("FAIL stall_done cyc=%0d accepted %0d exp 256 lastprev %b exp 1", cyc, acc, lastprev); end
         end
         pv = v0; pr = rdy; pd = d0; pl = l0; lastprev = pop && l0;
      end
      if (!fin) begin n_chk++; n_fail++; $display("FAIL stall_timeout accepted %0d exp 256", acc); end
      rdy = 1'b1;
   endtask

   task automatic test_reset_mid();
      int ecs[7] = '{1, 1, 0, 0, 0, 0, 0};
      int ev[7]  = '{0, 0, 0, 1, 1, 0, 0};
      int edn[7] = '{0, 0, 0, 0, 0, 1, 0};
      int eb[7]  = '{1, 1, 1, 1, 1, 1, 0};
      logic [3:0] ectl;
      @(negedge clk); st1 = 1'b1; base = 10'd40; len = 16'd8; rdy = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk); st1 = 1'b0; #1;
         n_chk++; if (cs1 !== 1'b1 || addr1 !== 10'(39 + c) || v1 !== (c == 4)) begin n_fail++; $display("FAIL rmid_pre c=%0d got cs %b addr %0d v %b", c, cs1, addr1, v1); end
      end
      n_chk++; if (d1 !== 32'd40) begin n_fail++; $display("FAIL rmid_head got %0d exp 40", d1); end
      rst_n = 1'b0; #1;
      n_chk++; if ({busy1, done1, cs1, v1, l1} !== 5'b0 || addr1 !== 10'd0 || d1 !== 32'd0) begin n_fail++; $display("FAIL rmid_reset ctl %b addr %0d data %0d exp 0", {busy1, done1, cs1, v1, l1}, addr1, d1); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk); st1 = 1'b1; base = 10'd0; len = 16'd2; rdy = 1'b1;
      for (int c = 1; c <= 7; c++) begin
         @(negedge clk); st1 = 1'b0; #1;
         ectl = {eb[c-1] != 0, edn[c-1] != 0, ecs[c-1] != 0, ev[c-1] != 0};
         n_chk++; if ({busy1, done1, cs1, v1} !== ectl) begin n_fail++; $display("FAIL rmid_ctl c=%0d got %b exp %b", c, {busy1, done1, cs1, v1}, ectl); end
         if (ecs[c-1] != 0) begin
            n_chk++; if (addr1 !== 10'(c - 1)) begin n_fail++; $display("FAIL rmid_addr c=%0d got %0d exp %0d", c, addr1, c - 1); end
         end
         if (ev[c-1] != 0) begin
            n_chk++; if (d1 !== 32'(c - 4) || l1 !== (c == 5)) begin n_fail++; $display("FAIL rmid_data c=%0d got %0d/%b exp %0d/%b", c, d1, l1, c - 4, c == 5); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wrap();
      test_len0();
      test_restart();
      test_stall();
      test_reset_mid();
      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
